// File: rtl/hazard_scoreboard_if.sv
// Hazard scoreboard bus: ID-stage operand/redirect information in, forwarding select and pipeline control out.
interface hazard_scoreboard_if #(
    parameter int FWD_STAGES = 3
) ();
    localparam int SELW = $clog2(FWD_STAGES + 1);

    logic            id_valid;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_use_rs1;
    logic            id_use_rs2;
    logic            id_wr;
    logic            id_is_load;
    logic            id_serial;
    logic            flush;
    logic            excep;
    logic [SELW-1:0] fwd_sel_a;
    logic [SELW-1:0] fwd_sel_b;
    logic            fwd_load_a;
    logic            fwd_load_b;
    logic            stall_if;
    logic            stall_id;
    logic            inv_id;
    logic            inv_ex;
    logic            inv_mem;
    logic [31:0]     stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_wr, id_is_load, id_serial, flush, excep,
        input  fwd_sel_a, fwd_sel_b, fwd_load_a, fwd_load_b,
               stall_if, stall_id, inv_id, inv_ex, inv_mem, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
               id_wr, id_is_load, id_serial, flush, excep,
        output fwd_sel_a, fwd_sel_b, fwd_load_a, fwd_load_b,
               stall_if, stall_id, inv_id, inv_ex, inv_mem, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: forwarding select, load-use stall, serialising drain.
// Define HAZARD_STALL_CNT_EN to add a wrapping stall-cycle counter on stall_cnt (tied to 0 otherwise).
module hazard_scoreboard #(
    parameter int FWD_STAGES = 3,
    parameter int LOAD_LAT   = 1
) (
    input logic                clk,
    input logic                reset,
    hazard_scoreboard_if.slave bus
);
    localparam int SELW = $clog2(FWD_STAGES + 1);

    typedef enum logic [1:0] {RUN, LSTALL, DRAIN} state_t;

    state_t              state;
    logic [FWD_STAGES:1] v;
    logic [FWD_STAGES:1] ld;
    logic [4:0]          rd [1:FWD_STAGES];

    logic [SELW-1:0] sel_a;
    logic [SELW-1:0] sel_b;
    logic            load_a;
    logic            load_b;
    logic            load_hazard;
    logic            busy;
    logic            serial_busy;
    logic            kill;
    logic            stall;
    logic            insert;

    // Scan oldest to youngest so the youngest matching producer is the one that sticks.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        load_a = 1'b0;
        load_b = 1'b0;
        for (int k = FWD_STAGES; k >= 1; k--) begin
            if (bus.id_use_rs1 && bus.id_rs1 != 5'd0 && v[k] && rd[k] == bus.id_rs1) begin
                sel_a  = SELW'(k);
                load_a = ld[k];
            end
            if (bus.id_use_rs2 && bus.id_rs2 != 5'd0 && v[k] && rd[k] == bus.id_rs2) begin
                sel_b  = SELW'(k);
                load_b = ld[k];
            end
        end
    end

    assign load_hazard = (load_a && int'(sel_a) <= LOAD_LAT) || (load_b && int'(sel_b) <= LOAD_LAT);
    assign busy        = |v[FWD_STAGES-1:1];
    assign serial_busy = bus.id_valid && bus.id_serial && busy;
    assign kill        = bus.flush || bus.excep;
    assign stall       = !kill && (load_hazard || serial_busy || (state == DRAIN && busy));
    assign insert      = bus.id_valid && !stall && !kill;

    assign bus.fwd_sel_a  = sel_a;
    assign bus.fwd_sel_b  = sel_b;
    assign bus.fwd_load_a = load_a;
    assign bus.fwd_load_b = load_b;
    assign bus.stall_if   = stall;
    assign bus.stall_id   = stall;
    // Redirect inputs are live during reset, so the invalidates are masked explicitly.
    assign bus.inv_id     = !reset && kill;
    assign bus.inv_ex     = !reset && (kill || stall);
    assign bus.inv_mem    = !reset && kill;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v     <= '0;
            state <= RUN;
        end else begin
            v[1] <= insert && bus.id_wr && bus.id_rd != 5'd0;
            for (int k = 2; k <= FWD_STAGES; k++) begin
                v[k] <= v[k-1];
            end
            // WB keeps whatever shifts into it; only the younger stages are squashed.
            if (bus.flush) begin
                v[2:1] <= '0;
            end else if (bus.excep) begin
                v[FWD_STAGES-1:1] <= '0;
            end

            if (kill) begin
                state <= RUN;
            end else if (state == DRAIN) begin
                state <= busy ? DRAIN : RUN;
            end else if (serial_busy) begin
                state <= DRAIN;
            end else if (load_hazard) begin
                state <= LSTALL;
            end else begin
                state <= RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        rd[1] <= bus.id_rd;
        ld[1] <= bus.id_is_load;
        for (int k = 2; k <= FWD_STAGES; k++) begin
            rd[k] <= rd[k-1];
            ld[k] <= ld[k-1];
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.stall_cnt = stall_cnt;
`else
    assign bus.stall_cnt = '0;
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus random traffic against a stage-list reference model.
module tb_hazard_scoreboard;
    localparam int N  = 3;
    localparam int LL = 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.FWD_STAGES(N)) bus ();
    hazard_scoreboard #(.FWD_STAGES(N), .LOAD_LAT(LL)) dut (.clk(clk), .reset(reset), .bus(bus));

    hazard_scoreboard_if #(.FWD_STAGES(5)) bus5 ();
    hazard_scoreboard #(.FWD_STAGES(5), .LOAD_LAT(3)) dut5 (.clk(clk), .reset(reset), .bus(bus5));

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       ld;
    } ent_t;

    ent_t        pipe [1:N];
    bit          draining;
    int unsigned stalls_seen;
    int          compared   = 0;
    int          mismatched = 0;

    bit exp_stall, exp_kill, exp_busy, exp_sbusy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input bit vld, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit wr, input bit ld, input bit ser);
        bus.id_valid   = vld;
        bus.id_rs1     = 5'(rs1);
        bus.id_use_rs1 = u1;
        bus.id_rs2     = 5'(rs2);
        bus.id_use_rs2 = u2;
        bus.id_rd      = 5'(rd);
        bus.id_wr      = wr;
        bus.id_is_load = ld;
        bus.id_serial  = ser;
        bus.flush      = 1'b0;
        bus.excep      = 1'b0;
    endtask

    task automatic idle5();
        bus5.id_valid = 0; bus5.id_rs1 = 0; bus5.id_rs2 = 0; bus5.id_rd = 0;
        bus5.id_use_rs1 = 0; bus5.id_use_rs2 = 0; bus5.id_wr = 0; bus5.id_is_load = 0;
        bus5.id_serial = 0; bus5.flush = 0; bus5.excep = 0;
    endtask

    // Youngest valid producer of a nonzero, used source register.
    function automatic void find(input logic [4:0] src, input logic use_s, output int sel, output bit ldf);
        sel = 0;
        ldf = 0;
        if (use_s && src != 5'd0) begin
            for (int k = 1; k <= N; k++) begin
                if (sel == 0 && pipe[k].v && pipe[k].rd == src) begin
                    sel = k;
                    ldf = pipe[k].ld;
                end
            end
        end
    endfunction

    task automatic eval(input string tag);
        int sa, sb;
        bit la, lb, haz;
        logic [31:0] exp_cnt;
        find(bus.id_rs1, bus.id_use_rs1, sa, la);
        find(bus.id_rs2, bus.id_use_rs2, sb, lb);
        haz = (la && sa <= LL) || (lb && sb <= LL);
        exp_busy = 0;
        for (int k = 1; k < N; k++) exp_busy |= pipe[k].v;
        exp_sbusy = bus.id_valid && bus.id_serial && exp_busy;
        exp_kill  = bus.flush || bus.excep;
        exp_stall = !exp_kill && (haz || exp_sbusy || (draining && exp_busy));
`ifdef HAZARD_STALL_CNT_EN
        exp_cnt = stalls_seen;
`else
        exp_cnt = 0;
`endif
        chk({tag, ".sel_a"},   32'(bus.fwd_sel_a), 32'(sa));
        chk({tag, ".sel_b"},   32'(bus.fwd_sel_b), 32'(sb));
        chk({tag, ".load_a"},  32'(bus.fwd_load_a), 32'(la));
        chk({tag, ".load_b"},  32'(bus.fwd_load_b), 32'(lb));
        chk({tag, ".stall_if"}, 32'(bus.stall_if), 32'(exp_stall));
        chk({tag, ".stall_id"}, 32'(bus.stall_id), 32'(exp_stall));
        chk({tag, ".inv_id"},  32'(bus.inv_id), 32'(exp_kill));
        chk({tag, ".inv_ex"},  32'(bus.inv_ex), 32'(exp_kill || exp_stall));
        chk({tag, ".inv_mem"}, 32'(bus.inv_mem), 32'(exp_kill));
        chk({tag, ".stall_cnt"}, bus.stall_cnt, exp_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        if (exp_stall) stalls_seen++;
        for (int k = N; k >= 2; k--) pipe[k] = pipe[k-1];
        pipe[1].v  = bus.id_valid && !exp_stall && !exp_kill && bus.id_wr && bus.id_rd != 5'd0;
        pipe[1].rd = bus.id_rd;
        pipe[1].ld = bus.id_is_load;
        if (bus.flush) begin
            for (int k = 1; k <= 2; k++) pipe[k].v = 1'b0;
        end else if (bus.excep) begin
            for (int k = 1; k < N; k++) pipe[k].v = 1'b0;
        end
        draining = !exp_kill && (draining ? exp_busy : exp_sbusy);
        #1;
    endtask

    task automatic cycle(input string tag);
        #3;
        eval(tag);
        advance();
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        set_id(1, 1, 1, 2, 1, 3, 1, 1, 1);
        bus.flush = 1'b1;
        bus.excep = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            #2;
            chk({tag, ".rst_stall_id"}, 32'(bus.stall_id), 0);
            chk({tag, ".rst_stall_if"}, 32'(bus.stall_if), 0);
            chk({tag, ".rst_inv_id"},   32'(bus.inv_id), 0);
            chk({tag, ".rst_inv_ex"},   32'(bus.inv_ex), 0);
            chk({tag, ".rst_inv_mem"},  32'(bus.inv_mem), 0);
            chk({tag, ".rst_sel_a"},    32'(bus.fwd_sel_a), 0);
            chk({tag, ".rst_cnt"},      bus.stall_cnt, 0);
            @(posedge clk);
            #1;
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int k = 1; k <= N; k++) pipe[k] = '0;
        draining    = 0;
        stalls_seen = 0;
    endtask

    initial begin
        reset = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle5();
        @(posedge clk);
        #1;
        do_reset("init");

        // Plain forwarding from EX.
        set_id(1, 0, 0, 0, 0, 5, 1, 0, 0); cycle("add_x5");
        set_id(1, 5, 1, 0, 0, 0, 0, 0, 0); #3; eval("use_x5");
        chk("fwd_ex.sel_a", 32'(bus.fwd_sel_a), 1);
        chk("fwd_ex.load_a", 32'(bus.fwd_load_a), 0);
        chk("fwd_ex.stall", 32'(bus.stall_id), 0);
        advance();

        // Load-use: one bubble, then forward the load data from MEM.
        set_id(1, 0, 0, 0, 0, 6, 1, 1, 0); cycle("lw_x6");
        set_id(1, 0, 0, 6, 1, 0, 0, 0, 0); #3; eval("lu1");
        chk("lu.stall_first", 32'(bus.stall_id), 1);
        chk("lu.inv_ex_first", 32'(bus.inv_ex), 1);
        advance();
        #3; eval("lu2");
        chk("lu.stall_second", 32'(bus.stall_id), 0);
        chk("lu.sel_b", 32'(bus.fwd_sel_b), 2);
        chk("lu.load_b", 32'(bus.fwd_load_b), 1);
        advance();

        // Youngest producer wins; x0 never forwards.
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 0); cycle("w7a");
        set_id(1, 0, 0, 0, 0, 0, 1, 0, 0); cycle("w0");
        set_id(1, 0, 0, 0, 0, 7, 1, 0, 0); cycle("w7b");
        set_id(1, 7, 1, 0, 1, 0, 0, 0, 0); #3; eval("yng");
        chk("yng.sel_a", 32'(bus.fwd_sel_a), 1);
        chk("x0.sel_b", 32'(bus.fwd_sel_b), 0);
        advance();

        // Serialising instruction drains EX and MEM.
        do_reset("pre_drain");
        set_id(1, 0, 0, 0, 0, 1, 1, 0, 0); cycle("w1");
        set_id(1, 0, 0, 0, 0, 2, 1, 0, 0); cycle("w2");
        set_id(1, 0, 0, 0, 0, 0, 0, 0, 1);
        #3; eval("dr0"); chk("drain.c0", 32'(bus.stall_id), 1); advance();
        #3; eval("dr1"); chk("drain.c1", 32'(bus.stall_id), 1); advance();
        #3; eval("dr2"); chk("drain.release", 32'(bus.stall_id), 0);
`ifdef HAZARD_STALL_CNT_EN
        chk("drain.cnt", bus.stall_cnt, 2);
`else
        chk("drain.cnt", bus.stall_cnt, 0);
`endif
        advance();

        // Flush while in the load stall; WB entry survives.
        set_id(1, 0, 0, 0, 0, 8, 1, 1, 0); cycle("lw_x8");
        set_id(1, 8, 1, 0, 0, 0, 0, 0, 0); cycle("lu_x8");
        bus.flush = 1'b1; #3; eval("fl");
        chk("flush.stall_if", 32'(bus.stall_if), 0);
        chk("flush.stall_id", 32'(bus.stall_id), 0);
        chk("flush.inv_id", 32'(bus.inv_id), 1);
        chk("flush.inv_ex", 32'(bus.inv_ex), 1);
        chk("flush.inv_mem", 32'(bus.inv_mem), 1);
        advance();
        set_id(1, 8, 1, 0, 0, 0, 0, 0, 0); #3; eval("after_fl");
        chk("flush.run_nostall", 32'(bus.stall_id), 0);
        chk("flush.wb_kept", 32'(bus.fwd_sel_a), 3);
        advance();

        // Exception squashes EX/MEM but not WB.
        set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); cycle("w3");
        set_id(1, 0, 0, 0, 0, 4, 1, 0, 0); cycle("w4");
        set_id(1, 0, 0, 0, 0, 9, 1, 0, 0); bus.excep = 1'b1; #3; eval("ex");
        chk("excep.inv_mem", 32'(bus.inv_mem), 1);
        advance();
        set_id(1, 3, 1, 4, 1, 0, 0, 0, 0); #3; eval("after_ex");
        chk("excep.wb_kept", 32'(bus.fwd_sel_a), 3);
        chk("excep.cleared", 32'(bus.fwd_sel_b), 0);
        advance();

        // Reset in the middle of a load stall.
        set_id(1, 0, 0, 0, 0, 10, 1, 1, 0); cycle("lw_x10");
        set_id(1, 10, 1, 0, 0, 0, 0, 0, 0); cycle("lu_x10");
        do_reset("mid");
        set_id(1, 10, 1, 0, 0, 0, 0, 0, 0); #3; eval("post_rst");
        chk("post_rst.stall", 32'(bus.stall_id), 0);
        chk("post_rst.sel_a", 32'(bus.fwd_sel_a), 0);
        advance();

        // Random traffic on a small register range to provoke overlaps.
        for (int i = 0; i < 400; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 4), $urandom_range(0, 1),
                   $urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 4),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
            bus.flush = $urandom_range(0, 15) == 0;
            bus.excep = $urandom_range(0, 15) == 0;
            cycle("rnd");
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Deeper pipe, load data forwardable only from stage 4 onwards.
        bus5.id_valid = 1; bus5.id_rd = 5'd9; bus5.id_wr = 1; bus5.id_is_load = 1;
        @(posedge clk); #1;
        idle5();
        repeat (2) begin @(posedge clk); #1; end
        bus5.id_valid = 1; bus5.id_rs1 = 5'd9; bus5.id_use_rs1 = 1;
        #3;
        chk("d5.stall", 32'(bus5.stall_id), 1);
        chk("d5.inv_ex", 32'(bus5.inv_ex), 1);
        chk("d5.sel_stage3", 32'(bus5.fwd_sel_a), 3);
        @(posedge clk); #4;
        chk("d5.release", 32'(bus5.stall_id), 0);
        chk("d5.sel", 32'(bus5.fwd_sel_a), 4);
        chk("d5.load", 32'(bus5.fwd_load_a), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
